ps2_field_entry: RTL and testbench

- Converts the raw PS/2 set-2 scan-code byte stream from the keyboard interface into NUM_FIELDS committed unsigned decimal parameters, e.g. velocity, angle and target coordinates, for the game/display logic.
- Replaces hard-wired constants at the top level.
- Adds break/extended-code filtering, typematic-repeat suppression, per-field editing, saturation and a fire strobe.

---
 rtl/ps2_field_entry.sv | 195 +++++++++++++++++++
 tb/tb_ps2_field_entry.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_field_entry.sv
// ps2_field_entry
// Turns the raw PS/2 set-2 scan-code byte stream into NUM_FIELDS committed
// unsigned decimal parameters. Break codes (F0 xx) and extended sequences
// (E0 xx / E0 F0 xx) are filtered out. Typematic repeats of a held key can be
// suppressed. Digits build the current entry with saturation, and Enter
// commits the entry to the field being edited.
//
// Ports:
//   clock        in   system clock, all state on rising edge
//   resetn       in   asynchronous active-low reset
//   key_data     in   raw scan-code byte
//   key_valid    in   one-cycle strobe, one byte per high cycle
//   field_values out  committed fields, field i at [i*FIELD_WIDTH +: FIELD_WIDTH]
//   edit_value   out  value currently being typed
//   edit_digits  out  digits accepted in the current entry
//   edit_field   out  index of the field being edited
//   commit       out  one-cycle pulse when a field is written
//   commit_field out  index written, valid while commit=1
//   fire         out  one-cycle pulse on a Space make
//   dbg_state    out  prefix FSM state (0 idle, 1 break, 2 ext, 3 ext-break)
//
// Handshake: key_valid has no back-pressure. Every cycle with key_valid=1
// delivers exactly one byte, and the block always consumes it on that edge.
module ps2_field_entry #(
    parameter int NUM_FIELDS    = 4,
    parameter int IDX_W         = 2,
    parameter int FIELD_WIDTH   = 8,
    parameter int MAX_DIGITS    = 3,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic [7:0]                        key_data,
    input  logic                              key_valid,
    output logic [NUM_FIELDS*FIELD_WIDTH-1:0] field_values,
    output logic [FIELD_WIDTH-1:0]            edit_value,
    output logic [3:0]                        edit_digits,
    output logic [IDX_W-1:0]                  edit_field,
    output logic                              commit,
    output logic [IDX_W-1:0]                  commit_field,
    output logic                              fire,
    output logic [1:0]                        dbg_state
);

    localparam int                 EXT_W       = FIELD_WIDTH + 4;
    localparam logic [IDX_W-1:0]   LAST_FIELD  = IDX_W'(NUM_FIELDS - 1);
    localparam logic [3:0]         DIGIT_LIMIT = 4'(MAX_DIGITS);

    localparam logic [7:0] KEY_BREAK = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_TAB   = 8'h0D;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t                          r_state;
    logic [7:0]                      r_held_key;
    logic [NUM_FIELDS*FIELD_WIDTH-1:0] r_fields;
    logic [FIELD_WIDTH-1:0]          r_edit_value;
    logic [3:0]                      r_edit_digits;
    logic [IDX_W-1:0]                r_edit_field;
    logic                            r_commit;
    logic [IDX_W-1:0]                r_commit_field;
    logic                            r_fire;

    logic                            w_is_digit;
    logic [3:0]                      w_digit;
    logic [EXT_W-1:0]                w_ext_sum;
    logic [FIELD_WIDTH-1:0]          w_sat_value;
    logic [IDX_W-1:0]                w_next_field;
    logic                            w_repeat;

    // Set-2 make codes for the main-row digits.
    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
        case (key_data)
            8'h45:   w_digit = 4'd0;
            8'h16:   w_digit = 4'd1;
            8'h1E:   w_digit = 4'd2;
            8'h26:   w_digit = 4'd3;
            8'h25:   w_digit = 4'd4;
            8'h2E:   w_digit = 4'd5;
            8'h36:   w_digit = 4'd6;
            8'h3D:   w_digit = 4'd7;
            8'h3E:   w_digit = 4'd8;
            8'h46:   w_digit = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    // value*10+9 always fits in FIELD_WIDTH+4 bits, so any carry into the
    // top nibble means the field width was exceeded and the result clamps.
    assign w_ext_sum    = EXT_W'(r_edit_value) * EXT_W'(10) + EXT_W'(w_digit);
    assign w_sat_value  = (|w_ext_sum[EXT_W-1:FIELD_WIDTH]) ? '1 : w_ext_sum[FIELD_WIDTH-1:0];
    assign w_next_field = (r_edit_field == LAST_FIELD) ? '0 : r_edit_field + 1'b1;
    assign w_repeat     = (REPEAT_FILTER != 0) && (key_data == r_held_key);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_held_key     <= 8'h00;
            r_fields       <= '0;
            r_edit_value   <= '0;
            r_edit_digits  <= '0;
            r_edit_field   <= '0;
            r_commit       <= 1'b0;
            r_commit_field <= '0;
            r_fire         <= 1'b0;
        end else begin
            // Strobes default low so a single byte can never hold them high twice.
            r_commit <= 1'b0;
            r_fire   <= 1'b0;
            if (key_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (key_data == KEY_BREAK) begin
                            r_state <= ST_BRK;
                        end else if (key_data == KEY_EXT) begin
                            r_state <= ST_EXT;
                        end else if (!w_repeat) begin
                            r_held_key <= key_data;
                            case (key_data)
                                KEY_ENTER: begin
                                    if (r_edit_digits != 4'd0) begin
                                        r_fields[int'(r_edit_field)*FIELD_WIDTH +: FIELD_WIDTH] <= r_edit_value;
                                        r_commit       <= 1'b1;
                                        r_commit_field <= r_edit_field;
                                        r_edit_value   <= '0;
                                        r_edit_digits  <= '0;
                                        r_edit_field   <= w_next_field;
                                    end
                                end
                                KEY_BKSP: begin
                                    r_edit_value  <= '0;
                                    r_edit_digits <= '0;
                                end
                                KEY_TAB: begin
                                    r_edit_value  <= '0;
                                    r_edit_digits <= '0;
                                    r_edit_field  <= w_next_field;
                                end
                                KEY_ESC: begin
                                    r_edit_value  <= '0;
                                    r_edit_digits <= '0;
                                    r_edit_field  <= '0;
                                end
                                KEY_SPACE: begin
                                    r_fire <= 1'b1;
                                end
                                default: begin
                                    if (w_is_digit && (r_edit_digits < DIGIT_LIMIT)) begin
                                        r_edit_value  <= w_sat_value;
                                        r_edit_digits <= r_edit_digits + 4'd1;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_BRK: begin
                        // Releasing the held key re-arms it for the repeat filter.
                        if (key_data == r_held_key) begin
                            r_held_key <= 8'h00;
                        end
                        r_state <= ST_IDLE;
                    end
                    ST_EXT: begin
                        r_state <= (key_data == KEY_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign field_values = r_fields;
    assign edit_value   = r_edit_value;
    assign edit_digits  = r_edit_digits;
    assign edit_field   = r_edit_field;
    assign commit       = r_commit;
    assign commit_field = r_commit_field;
    assign fire         = r_fire;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ps2_field_entry.sv
module tb_ps2_field_entry;

  localparam int NF = 4;
  localparam int FW = 8;
  localparam int MAXV = 255;
  localparam int MAXD = 3;
  localparam logic [7:0] DIG_CODES [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  logic [7:0] key_data;
  logic key_valid;
  always #5 clock = ~clock;

  // ---------------- DUTs: repeat filter on (u0) and off (u1) ----------------
  logic [NF*FW-1:0] fv0, fv1;
  logic [FW-1:0] ev0, ev1;
  logic [3:0] ed0, ed1;
  logic [1:0] ef0, ef1, cf0, cf1, ds0, ds1;
  logic cm0, cm1, fi0, fi1;

  ps2_field_entry #(.NUM_FIELDS(NF), .IDX_W(2), .FIELD_WIDTH(FW), .MAX_DIGITS(MAXD), .REPEAT_FILTER(1)) dut (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_valid(key_valid),
    .field_values(fv0), .edit_value(ev0), .edit_digits(ed0), .edit_field(ef0),
    .commit(cm0), .commit_field(cf0), .fire(fi0), .dbg_state(ds0));

  ps2_field_entry #(.NUM_FIELDS(NF), .IDX_W(2), .FIELD_WIDTH(FW), .MAX_DIGITS(MAXD), .REPEAT_FILTER(0)) dut_nr (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_valid(key_valid),
    .field_values(fv1), .edit_value(ev1), .edit_digits(ed1), .edit_field(ef1),
    .commit(cm1), .commit_field(cf1), .fire(fi1), .dbg_state(ds1));

  logic [31:0] a_fv [2];
  logic [31:0] a_ev [2];
  logic [31:0] a_ed [2];
  logic [31:0] a_ef [2];
  logic [31:0] a_cm [2];
  logic [31:0] a_cf [2];
  logic [31:0] a_fi [2];
  assign a_fv[0] = 32'(fv0);
  assign a_fv[1] = 32'(fv1);
  assign a_ev[0] = 32'(ev0);
  assign a_ev[1] = 32'(ev1);
  assign a_ed[0] = 32'(ed0);
  assign a_ed[1] = 32'(ed1);
  assign a_ef[0] = 32'(ef0);
  assign a_ef[1] = 32'(ef1);
  assign a_cm[0] = 32'(cm0);
  assign a_cm[1] = 32'(cm1);
  assign a_cf[0] = 32'(cf0);
  assign a_cf[1] = 32'(cf1);
  assign a_fi[0] = 32'(fi0);
  assign a_fi[1] = 32'(fi1);

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keyboard-level view: which prefix bytes are pending, which key is held,
  // and the entry/field contents as plain integers.
  int m_rf [2] = '{1, 0};
  int m_fields [2][NF];
  int m_val [2];
  int m_dig [2];
  int m_fld [2];
  int m_held [2];
  int m_commit [2];
  int m_cfield [2];
  int m_fire [2];
  bit m_saw_f0 [2];
  bit m_saw_e0 [2];

  function automatic int digit_of(input logic [7:0] b);
    for (int k = 0; k < 10; k++)
      if (DIG_CODES[k] == b) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < NF; f++) m_fields[i][f] = 0;
      m_val[i] = 0; m_dig[i] = 0; m_fld[i] = 0; m_held[i] = 0;
      m_commit[i] = 0; m_cfield[i] = 0; m_fire[i] = 0;
      m_saw_f0[i] = 0; m_saw_e0[i] = 0;
    end
  endtask

  task automatic model_idle();
    for (int i = 0; i < 2; i++) begin
      m_commit[i] = 0;
      m_fire[i] = 0;
    end
  endtask

  task automatic model_byte(input int i, input logic [7:0] b);
    int d;
    m_commit[i] = 0;
    m_fire[i] = 0;
    if (m_saw_e0[i]) begin
      if (!m_saw_f0[i] && b == 8'hF0) m_saw_f0[i] = 1;
      else begin m_saw_e0[i] = 0; m_saw_f0[i] = 0; end
      return;
    end
    if (m_saw_f0[i]) begin
      if (int'(b) == m_held[i]) m_held[i] = 0;
      m_saw_f0[i] = 0;
      return;
    end
    if (b == 8'hF0) begin m_saw_f0[i] = 1; return; end
    if (b == 8'hE0) begin m_saw_e0[i] = 1; return; end
    if (m_rf[i] != 0 && int'(b) == m_held[i]) return;
    m_held[i] = int'(b);
    d = digit_of(b);
    if (d >= 0) begin
      if (m_dig[i] < MAXD) begin
        m_val[i] = m_val[i] * 10 + d;
        if (m_val[i] > MAXV) m_val[i] = MAXV;
        m_dig[i]++;
      end
    end else if (b == 8'h5A) begin
      if (m_dig[i] > 0) begin
        m_fields[i][m_fld[i]] = m_val[i];
        m_commit[i] = 1;
        m_cfield[i] = m_fld[i];
        m_val[i] = 0; m_dig[i] = 0;
        m_fld[i] = (m_fld[i] + 1) % NF;
      end
    end else if (b == 8'h66) begin
      m_val[i] = 0; m_dig[i] = 0;
    end else if (b == 8'h0D) begin
      m_val[i] = 0; m_dig[i] = 0;
      m_fld[i] = (m_fld[i] + 1) % NF;
    end else if (b == 8'h76) begin
      m_val[i] = 0; m_dig[i] = 0; m_fld[i] = 0;
    end else if (b == 8'h29) begin
      m_fire[i] = 1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int f = 0; f < NF; f++)
        check($sformatf("%s u%0d field%0d", tag, i, f), (a_fv[i] >> (FW * f)) & 32'hFF, 32'(m_fields[i][f]));
      check($sformatf("%s u%0d edit_value", tag, i), a_ev[i], 32'(m_val[i]));
      check($sformatf("%s u%0d edit_digits", tag, i), a_ed[i], 32'(m_dig[i]));
      check($sformatf("%s u%0d edit_field", tag, i), a_ef[i], 32'(m_fld[i]));
      check($sformatf("%s u%0d commit", tag, i), a_cm[i], 32'(m_commit[i]));
      check($sformatf("%s u%0d fire", tag, i), a_fi[i], 32'(m_fire[i]));
      if (m_commit[i] != 0)
        check($sformatf("%s u%0d commit_field", tag, i), a_cf[i], 32'(m_cfield[i]));
    end
  endtask

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic send(input logic [7:0] b, input string tag);
    key_data = b;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    if (resetn) begin
      model_byte(0, b);
      model_byte(1, b);
    end
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) begin
      @(negedge clock);
      model_idle();
      check_all(tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all(tag);
    #1 resetn = 1'b1;
    @(negedge clock);
    check_all({tag, " release"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int r;
    resetn = 1'b0;
    key_valid = 1'b0;
    key_data = 8'h00;
    model_reset();
    @(negedge clock);

    // Bytes while held in reset must have no effect.
    send(8'h16, "rst held");
    send(8'h5A, "rst held");
    send(8'h29, "rst held");
    resetn = 1'b1;
    idle(10, "post rst");

    // Basic commit: 1,2,0 Enter -> field 0 = 120.
    send(8'h16, "basic"); send(8'hF0, "basic"); send(8'h16, "basic");
    send(8'h1E, "basic"); send(8'hF0, "basic"); send(8'h1E, "basic");
    send(8'h45, "basic"); send(8'hF0, "basic"); send(8'h45, "basic");
    send(8'h5A, "basic");
    check("basic field0 const", a_fv[0] & 32'hFF, 32'd120);
    check("basic commit const", a_cm[0], 32'd1);
    check("basic commit_field const", a_cf[0], 32'd0);
    check("basic edit_field const", a_ef[0], 32'd1);
    idle(1, "basic after");

    // Saturation: 999 -> 255 in field 1.
    repeat (3) begin
      send(8'h46, "sat"); send(8'hF0, "sat"); send(8'h46, "sat");
    end
    send(8'h5A, "sat");
    check("sat field1 const", (a_fv[0] >> 8) & 32'hFF, 32'd255);

    // Digit limit: fourth digit ignored.
    send(8'h16, "lim"); send(8'hF0, "lim"); send(8'h16, "lim");
    send(8'h1E, "lim"); send(8'hF0, "lim"); send(8'h1E, "lim");
    send(8'h26, "lim"); send(8'hF0, "lim"); send(8'h26, "lim");
    send(8'h25, "lim");
    check("lim edit_value const", a_ev[0], 32'd123);
    check("lim edit_digits const", a_ed[0], 32'd3);
    send(8'h66, "bksp");

    // Repeat filter on vs off.
    send(8'h16, "rpt"); send(8'h16, "rpt"); send(8'h16, "rpt");
    send(8'hF0, "rpt"); send(8'h16, "rpt"); send(8'h16, "rpt");
    check("rpt filtered const", a_ev[0], 32'd11);
    check("rpt unfiltered const", a_ev[1], 32'd111);
    send(8'h66, "bksp");

    // Navigation: Esc, then four Tabs wrap back to 0.
    send(8'h76, "esc");
    for (int t = 0; t < 4; t++) begin
      send(8'h0D, "tab"); send(8'hF0, "tab"); send(8'h0D, "tab");
    end
    check("tab wrap const", a_ef[0], 32'd0);

    // Extended Enter make/break must not commit a pending entry.
    send(8'h16, "ext"); send(8'hF0, "ext"); send(8'h16, "ext");
    send(8'hE0, "ext"); send(8'h5A, "ext");
    send(8'hE0, "ext"); send(8'hF0, "ext"); send(8'h5A, "ext");
    check("ext entry intact const", a_ev[0], 32'd1);
    send(8'h0D, "tab2");
    send(8'h76, "esc2");
    check("esc field const", a_ef[0], 32'd0);
    send(8'h5A, "empty enter");
    check("empty enter const", a_cm[0], 32'd0);

    // Reset in the middle of a break sequence, then fire.
    send(8'h16, "mid"); send(8'hF0, "mid");
    pulse_reset("mid rst");
    send(8'h16, "mid after");
    check("mid after const", a_ev[0], 32'd1);
    send(8'h29, "fire");
    check("fire const", a_fi[0], 32'd1);
    idle(1, "fire low");

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) b = DIG_CODES[$urandom_range(0, 9)];
      else if (r < 56) b = 8'hF0;
      else if (r < 61) b = 8'hE0;
      else if (r < 71) b = 8'h5A;
      else if (r < 74) b = 8'h66;
      else if (r < 80) b = 8'h0D;
      else if (r < 83) b = 8'h76;
      else if (r < 88) b = 8'h29;
      else b = 8'($urandom_range(0, 255));
      send(b, "rand");
      r = $urandom_range(0, 99);
      if (r < 20) idle($urandom_range(1, 2), "rand idle");
      else if (r == 99) pulse_reset("rand rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
